// File: rtl/ex_mem_skid_pkg.sv
// Shared constants and enums for the EX->MEM skid register.
// Occupancy encodings and head-source select used by ex_mem_skid.
package ex_mem_skid_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  typedef enum logic [1:0] {
    EXMEM_EMPTY = 2'd0,
    EXMEM_ONE   = 2'd1,
    EXMEM_FULL  = 2'd2
  } occ_e;

  typedef enum logic [1:0] {
    HEAD_FROM_EX   = 2'd0,
    HEAD_FROM_SKID = 2'd1,
    HEAD_CLEAR     = 2'd2
  } head_src_e;

endpackage

// File: rtl/ex_mem_entry.sv
// One {valid,rw,wreg,wdata} slot of the EX->MEM skid buffer.
// Async clear on rst, synchronous flush, and a load strobe.
module ex_mem_entry #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rw,
  input  logic              d_wreg,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              q_valid,
  output logic [ADDR_W-1:0] q_rw,
  output logic              q_wreg,
  output logic [DATA_W-1:0] q_wdata
);

  // Flush wins over load so a same-cycle accept is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_rw    <= '0;
      q_wreg  <= 1'b0;
      q_wdata <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_rw    <= '0;
      q_wreg  <= 1'b0;
      q_wdata <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_rw    <= d_rw;
      q_wreg  <= d_wreg;
      q_wdata <= d_wdata;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a 2-entry skid buffer and registered ex_ready_o.
// Define EX_MEM_FWD_EN to expose head/skid entries to the ID-stage forwarding mux.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_rw_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_rw_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd0_wreg_o,
  output logic [ADDR_W-1:0] fwd0_rw_o,
  output logic [DATA_W-1:0] fwd0_wdata_o,
  output logic              fwd1_wreg_o,
  output logic [ADDR_W-1:0] fwd1_rw_o,
  output logic [DATA_W-1:0] fwd1_wdata_o
`endif
);

  occ_e              state, next_state;
  head_src_e         head_src;
  logic              accept, deliver;
  logic              head_load, skid_load, skid_fill;
  logic              head_d_valid, head_d_wreg;
  logic [ADDR_W-1:0] head_d_rw;
  logic [DATA_W-1:0] head_d_wdata;
  logic              head_valid, head_wreg, skid_valid, skid_wreg;
  logic [ADDR_W-1:0] head_rw, skid_rw;
  logic [DATA_W-1:0] head_wdata, skid_wdata;

  assign accept  = ex_valid_i & ex_ready_o;
  assign deliver = mem_valid_o & mem_ready_i;

  always_comb begin
    next_state = state;
    head_load  = 1'b0;
    head_src   = HEAD_FROM_EX;
    skid_load  = 1'b0;
    skid_fill  = 1'b0;
    unique case (state)
      EXMEM_EMPTY: begin
        if (accept) begin
          next_state = EXMEM_ONE;
          head_load  = 1'b1;
        end
      end
      EXMEM_ONE: begin
        if (accept && !deliver) begin
          next_state = EXMEM_FULL;
          skid_load  = 1'b1;
          skid_fill  = 1'b1;
        end else if (accept && deliver) begin
          head_load = 1'b1;
        end else if (deliver) begin
          next_state = EXMEM_EMPTY;
          head_load  = 1'b1;
          head_src   = HEAD_CLEAR;
        end
      end
      EXMEM_FULL: begin
        if (deliver) begin
          next_state = EXMEM_ONE;
          head_load  = 1'b1;
          head_src   = HEAD_FROM_SKID;
          skid_load  = 1'b1;
        end
      end
      default: next_state = EXMEM_EMPTY;
    endcase
    if (flush_i) next_state = EXMEM_EMPTY;
  end

  always_comb begin
    head_d_valid = 1'b0;
    head_d_rw    = '0;
    head_d_wreg  = 1'b0;
    head_d_wdata = '0;
    case (head_src)
      HEAD_FROM_EX: begin
        head_d_valid = 1'b1;
        head_d_rw    = ex_rw_i;
        head_d_wreg  = ex_wreg_i;
        head_d_wdata = ex_wdata_i;
      end
      HEAD_FROM_SKID: begin
        head_d_valid = skid_valid;
        head_d_rw    = skid_rw;
        head_d_wreg  = skid_wreg;
        head_d_wdata = skid_wdata;
      end
      default: ;
    endcase
  end

  // ex_ready_o is registered from the next occupancy so MEM back-pressure never reaches EX combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EXMEM_EMPTY;
      ex_ready_o <= 1'b1;
    end else begin
      state      <= next_state;
      ex_ready_o <= (next_state != EXMEM_FULL);
    end
  end

  ex_mem_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_head (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_i),
    .load    (head_load),
    .d_valid (head_d_valid),
    .d_rw    (head_d_rw),
    .d_wreg  (head_d_wreg),
    .d_wdata (head_d_wdata),
    .q_valid (head_valid),
    .q_rw    (head_rw),
    .q_wreg  (head_wreg),
    .q_wdata (head_wdata)
  );

  ex_mem_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_i),
    .load    (skid_load),
    .d_valid (skid_fill),
    .d_rw    (skid_fill ? ex_rw_i : '0),
    .d_wreg  (skid_fill & ex_wreg_i),
    .d_wdata (skid_fill ? ex_wdata_i : '0),
    .q_valid (skid_valid),
    .q_rw    (skid_rw),
    .q_wreg  (skid_wreg),
    .q_wdata (skid_wdata)
  );

  assign mem_valid_o = head_valid;
  assign mem_rw_o    = head_rw;
  assign mem_wreg_o  = head_wreg & head_valid;
  assign mem_wdata_o = head_wdata;

`ifdef EX_MEM_FWD_EN
  // The skid entry is younger, so the ID mux must prefer fwd1 on an rw match.
  assign fwd0_wreg_o  = head_wreg & head_valid;
  assign fwd0_rw_o    = head_rw;
  assign fwd0_wdata_o = head_wdata;
  assign fwd1_wreg_o  = skid_wreg & skid_valid;
  assign fwd1_rw_o    = skid_rw;
  assign fwd1_wdata_o = skid_wdata;
`endif

endmodule
